// File: rtl/secuenciador_pkg.sv
// Shared state encoding and sweep mode codes for the counter sweep sequencer.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN_UP   = 3'd2,
    S_RUN_DOWN = 3'd3,
    S_DWELL    = 3'd4,
    S_CLR      = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;

endpackage

// File: rtl/secuenciador_dwell_timer.sv
// W-bit loadable down-counter; expired is high while the count sits at zero.
module secuenciador_dwell_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/secuenciador_contador.sv
// Sweep controller for the universal binary counter: up, down and ping-pong sweeps.
// Define SEQ_PINGPONG_EN to enable up-then-down chaining for mode 10.
module secuenciador_contador
  import secuenciador_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 4,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   mode,
  input  logic [N-1:0] d_start,
  input  logic [W-1:0] dwell,
  input  logic [R-1:0] reps,
  input  logic [N-1:0] cnt_q,
  input  logic         cnt_max_tick,
  input  logic         cnt_min_tick,
  output logic         cnt_syn_clr,
  output logic         cnt_load,
  output logic         cnt_en,
  output logic         cnt_up,
  output logic [N-1:0] cnt_d,
  output logic         busy,
  output logic         done,
  output logic [R-1:0] sweeps_left
);

  state_t       state;
  logic [1:0]   mode_q;
  logic [W-1:0] dwell_q;
  logic         dwell_to_down;
  logic         dwell_expired;
  logic         more_reps;
  logic         unused_cnt_q;

  // The sweep is steered by the ticks alone; q is part of the counter bundle only.
  assign unused_cnt_q = ^cnt_q;

  assign more_reps = (sweeps_left > R'(1));
  assign busy      = (state != S_IDLE);
  assign cnt_en    = ((state == S_RUN_UP)   && !cnt_max_tick) ||
                     ((state == S_RUN_DOWN) && !cnt_min_tick);

  // Timer is held at dwell-1 outside DWELL so it expires on the last dwell cycle.
  secuenciador_dwell_timer #(.W(W)) u_dwell (
    .clk      (clk),
    .load     (state != S_DWELL),
    .load_val (dwell_q - W'(1)),
    .expired  (dwell_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      sweeps_left   <= '0;
      cnt_up        <= 1'b1;
      cnt_load      <= 1'b0;
      cnt_syn_clr   <= 1'b0;
      done          <= 1'b0;
      cnt_d         <= '0;
      dwell_to_down <= 1'b0;
    end else begin
      cnt_load    <= 1'b0;
      cnt_syn_clr <= 1'b0;
      done        <= 1'b0;
      if (abort && (state != S_IDLE) && (state != S_CLR)) begin
        state       <= S_CLR;
        cnt_syn_clr <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (start && !abort) begin
            state         <= S_LOAD;
            cnt_load      <= 1'b1;
            mode_q        <= mode;
            cnt_d         <= d_start;
            dwell_q       <= dwell;
            sweeps_left   <= (reps == '0) ? R'(1) : reps;
            dwell_to_down <= 1'b0;
          end
          S_LOAD: begin
            if (mode_q == MODE_DOWN) begin
              state  <= S_RUN_DOWN;
              cnt_up <= 1'b0;
            end else begin
              state  <= S_RUN_UP;
              cnt_up <= 1'b1;
            end
          end
          S_RUN_UP: if (cnt_max_tick) begin
`ifdef SEQ_PINGPONG_EN
            if (mode_q == MODE_PP) begin
              if (dwell_q != '0) begin
                state         <= S_DWELL;
                dwell_to_down <= 1'b1;
              end else begin
                state  <= S_RUN_DOWN;
                cnt_up <= 1'b0;
              end
            end else
`endif
            if (dwell_q != '0) begin
              state <= S_DWELL;
            end else if (more_reps) begin
              state       <= S_LOAD;
              cnt_load    <= 1'b1;
              sweeps_left <= sweeps_left - R'(1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_RUN_DOWN: if (cnt_min_tick) begin
            if (dwell_q != '0) begin
              state <= S_DWELL;
            end else if (more_reps) begin
              state       <= S_LOAD;
              cnt_load    <= 1'b1;
              sweeps_left <= sweeps_left - R'(1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_DWELL: if (dwell_expired) begin
            if (dwell_to_down) begin
              state         <= S_RUN_DOWN;
              cnt_up        <= 1'b0;
              dwell_to_down <= 1'b0;
            end else if (more_reps) begin
              state       <= S_LOAD;
              cnt_load    <= 1'b1;
              sweeps_left <= sweeps_left - R'(1);
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_CLR:   state <= S_IDLE;
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_secuenciador_contador.sv
// Directed bench for secuenciador_contador driving a behavioural universal counter.
module tb_secuenciador_contador;

  localparam int N = 3;
  localparam int W = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         reset, cnt_rst;
  logic         start, abort;
  logic [1:0]   mode;
  logic [N-1:0] d_start;
  logic [W-1:0] dwell;
  logic [R-1:0] reps;
  logic [N-1:0] cnt_q;
  logic         cnt_max_tick, cnt_min_tick;
  logic         cnt_syn_clr, cnt_load, cnt_en, cnt_up;
  logic [N-1:0] cnt_d;
  logic         busy, done;
  logic [R-1:0] sweeps_left;

  int n_checks = 0;
  int n_err    = 0;

  logic [127:0] q_tr, sl_tr, d_tr;
  int           n_busy, n_en;
  logic         found;
  int           late_done;

  always #5 clk = ~clk;

  secuenciador_contador #(.N(N), .W(W), .R(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .mode         (mode),
    .d_start      (d_start),
    .dwell        (dwell),
    .reps         (reps),
    .cnt_q        (cnt_q),
    .cnt_max_tick (cnt_max_tick),
    .cnt_min_tick (cnt_min_tick),
    .cnt_syn_clr  (cnt_syn_clr),
    .cnt_load     (cnt_load),
    .cnt_en       (cnt_en),
    .cnt_up       (cnt_up),
    .cnt_d        (cnt_d),
    .busy         (busy),
    .done         (done),
    .sweeps_left  (sweeps_left)
  );

  // Universal counter model: clear > load > enable, combinational ticks.
  always_ff @(posedge clk) begin
    if (cnt_rst)          cnt_q <= '0;
    else if (cnt_syn_clr) cnt_q <= '0;
    else if (cnt_load)    cnt_q <= cnt_d;
    else if (cnt_en)      cnt_q <= cnt_up ? cnt_q + N'(1) : cnt_q - N'(1);
  end
  assign cnt_max_tick = (cnt_q == '1);
  assign cnt_min_tick = (cnt_q == '0);

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one command and trace q, sweeps_left and done over every busy cycle.
  task automatic run_cmd(input logic [1:0] m, input logic [N-1:0] ds,
                         input logic [W-1:0] dw, input logic [R-1:0] rp, input bit hold);
    @(negedge clk);
    mode = m; d_start = ds; dwell = dw; reps = rp; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    mode = ~m; d_start = ~ds; dwell = ~dw; reps = ~rp;
    q_tr = '0; sl_tr = '0; d_tr = '0; n_busy = 0; n_en = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      q_tr  = {q_tr[123:0], 1'b0, cnt_q};
      sl_tr = {sl_tr[123:0], sweeps_left};
      d_tr  = {d_tr[126:0], done};
      n_busy++;
      if (cnt_en) n_en++;
    end
    start = 1'b0;
    check("timeout", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    reset = 1'b1; cnt_rst = 1'b1; start = 1'b0; abort = 1'b0;
    mode = '0; d_start = '0; dwell = '0; reps = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; cnt_rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_up", {127'd0, cnt_up}, 128'd1);
    check("rst_done", {127'd0, done}, 128'd0);
    check("rst_load", {127'd0, cnt_load}, 128'd0);
    check("rst_clr", {127'd0, cnt_syn_clr}, 128'd0);
    check("rst_en", {127'd0, cnt_en}, 128'd0);
    check("rst_sweeps", 128'(sweeps_left), 128'd0);
    check("rst_d", 128'(cnt_d), 128'd0);

    // One-shot up from 3
    run_cmd(2'b00, 3'd3, 4'd0, 4'd1, 1'b0);
    check("up_q", q_tr, 128'h0345677);
    check("up_busy", 128'(n_busy), 128'd7);
    check("up_en", 128'(n_en), 128'd4);
    check("up_done", d_tr, 128'd1);
    check("up_cnt_d", 128'(cnt_d), 128'd3);

    // Down from 2, two repetitions, start held high throughout
    run_cmd(2'b01, 3'd2, 4'd0, 4'd2, 1'b1);
    check("dn_q", q_tr, 128'h721002100);
    check("dn_sweeps", sl_tr, 128'h222211111);
    check("dn_busy", 128'(n_busy), 128'd9);
    check("dn_en", 128'(n_en), 128'd4);
    check("dn_done", d_tr, 128'd1);

    // Mode 11 acts as up; reps=0 runs once
    run_cmd(2'b11, 3'd6, 4'd0, 4'd0, 1'b0);
    check("m3_q", q_tr, 128'h0677);
    check("m3_sweeps", sl_tr, 128'h1111);
    check("m3_en", 128'(n_en), 128'd1);
    check("m3_done", d_tr, 128'd1);

    // Start value already terminal
    run_cmd(2'b00, 3'd7, 4'd0, 4'd1, 1'b0);
    check("term_q", q_tr, 128'h777);
    check("term_busy", 128'(n_busy), 128'd3);
    check("term_en", 128'(n_en), 128'd0);
    check("term_done", d_tr, 128'd1);

    // Ping-pong from 5 with dwell 2
    run_cmd(2'b10, 3'd5, 4'd2, 4'd1, 1'b0);
`ifdef SEQ_PINGPONG_EN
    check("pp_q", q_tr, 128'h75677776543210000);
    check("pp_busy", 128'(n_busy), 128'd17);
    check("pp_en", 128'(n_en), 128'd9);
`else
    check("pp_q", q_tr, 128'h7567777);
    check("pp_busy", 128'(n_busy), 128'd7);
    check("pp_en", 128'(n_en), 128'd2);
`endif
    check("pp_done", d_tr, 128'd1);

    // start together with abort in IDLE
    @(negedge clk);
    mode = 2'b00; d_start = 3'd1; dwell = '0; reps = 4'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    check("sa_busy", {127'd0, busy}, 128'd0);
    check("sa_load", {127'd0, cnt_load}, 128'd0);
    start = 1'b0; abort = 1'b0;

    // Abort while q=4 in an up sweep
    @(negedge clk);
    mode = 2'b00; d_start = 3'd2; dwell = '0; reps = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && cnt_q == 3'd4) begin found = 1'b1; break; end
    end
    check("ab_reach", {127'd0, found}, 128'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("ab_clr", {127'd0, cnt_syn_clr}, 128'd1);
    check("ab_en", {127'd0, cnt_en}, 128'd0);
    check("ab_busy", {127'd0, busy}, 128'd1);
    check("ab_done", {127'd0, done}, 128'd0);
    @(negedge clk);
    check("ab_q", 128'(cnt_q), 128'd0);
    check("ab_idle", {127'd0, busy}, 128'd0);
    check("ab_done2", {127'd0, done}, 128'd0);

    // Reset asserted during DWELL
    @(negedge clk);
    mode = 2'b00; d_start = 3'd6; dwell = 4'd3; reps = 4'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && cnt_q == 3'd7) begin found = 1'b1; break; end
    end
    check("rd_reach", {127'd0, found}, 128'd1);
    @(negedge clk);
    check("rd_dwell_en", {127'd0, cnt_en}, 128'd0);
    check("rd_dwell_up", {127'd0, cnt_up}, 128'd1);
    check("rd_dwell_busy", {127'd0, busy}, 128'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rd_busy", {127'd0, busy}, 128'd0);
    check("rd_up", {127'd0, cnt_up}, 128'd1);
    check("rd_done", {127'd0, done}, 128'd0);
    check("rd_sweeps", 128'(sweeps_left), 128'd0);
    check("rd_q", 128'(cnt_q), 128'd7);
    late_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("rd_quiet", 128'(late_done), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
